// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: Moore FSM that sequences fetch, decode, memory,
// ALU, branch and jump steps. Define MC_ADDI_EN to add the addi execute/writeback path.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       pcwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
`ifdef MC_ADDI_EN
        ,
        ADDIEXEC = 4'd10,
        ADDIWB   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= next_state;
    end

    assign state = state_q;

    // mem_ready handshake: a memory state keeps presenting its request every
    // cycle and leaves only in the cycle where mem_ready=1 (access completes).
    always_comb begin
        next_state = state_q;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        branch     = 1'b0;
        pcwrite    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      next_state = ADDIEXEC;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = FETCH;
                end
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
`ifdef MC_ADDI_EN
            ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase
        // Reset must silence every side effect immediately, even mid-wait.
        if (rst) begin
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
